bus_slave: RTL and testbench

BUS_SLAVE -- requirements
Module: bus_slave

---
 rtl/bus_slave_if.sv | 26 ++
 rtl/bus_slave.sv | 106 ++++++++++
 tb/tb_bus_slave.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_slave_if.sv
// Bus-controller and memory-side signal bundle for bus_slave.
interface bus_slave_if;
    logic        rdy;
    logic [1:0]  bus_ctrl;
    logic [7:0]  bus_in;
    logic        bus_we;
    logic        ack;
    logic [7:0]  bus_out;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        err;

    modport slave (
        input  rdy, bus_ctrl, bus_in, bus_we, mem_rdata, mem_ack,
        output ack, bus_out, mem_req, mem_we, mem_addr, mem_wdata, err
    );

    modport master (
        output rdy, bus_ctrl, bus_in, bus_we, mem_rdata, mem_ack,
        input  ack, bus_out, mem_req, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/bus_slave.sv
// Byte-serial bus slave: three address phases build a 24-bit address, a DATA
// phase performs one memory access with timeout, every phase ends in an ack.
module bus_slave #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    bus_slave_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_MEM_WAIT, S_ACK_HI} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_rdy_m, r_rdy_s, r_rdy_d;
    logic        w_rise, w_tmo, w_ack, w_mem_req;
    logic [23:0] r_addr;
    logic [7:0]  r_cnt;
    logic        r_mem_we;
    logic [23:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic [7:0]  r_bus_out;
    logic        r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdy_m <= 1'b0;
            r_rdy_s <= 1'b0;
            r_rdy_d <= 1'b0;
        end else begin
            r_rdy_m <= bus.rdy;
            r_rdy_s <= r_rdy_m;
            r_rdy_d <= r_rdy_s;
        end
    end

    assign w_rise = r_rdy_s & ~r_rdy_d;
    // r_cnt counts edges since mem_req rose; expiry lands TIMEOUT edges later
    assign w_tmo  = (r_cnt == TIMEOUT - 8'd1);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_rise) w_state_nxt = (bus.bus_ctrl == 2'd3) ? S_MEM_WAIT : S_ACK_HI;
            S_MEM_WAIT: if (bus.mem_ack || w_tmo) w_state_nxt = S_ACK_HI;
            S_ACK_HI:   if (!r_rdy_s) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ack     = (r_state == S_ACK_HI);
        w_mem_req = (r_state == S_MEM_WAIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr      <= 24'd0;
            r_cnt       <= 8'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 24'd0;
            r_mem_wdata <= 8'd0;
            r_bus_out   <= 8'd0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_rise) begin
                    r_cnt <= 8'd0;
                    case (bus.bus_ctrl)
                        2'd0: r_addr[7:0]   <= bus.bus_in;
                        2'd1: r_addr[15:8]  <= bus.bus_in;
                        2'd2: r_addr[23:16] <= bus.bus_in;
                        default: begin
                            r_mem_we    <= bus.bus_we;
                            r_mem_addr  <= r_addr;
                            r_mem_wdata <= bus.bus_in;
                        end
                    endcase
                end
                // an ack coinciding with expiry wins
                S_MEM_WAIT: begin
                    if (bus.mem_ack) begin
                        if (!r_mem_we) r_bus_out <= bus.mem_rdata;
                    end else if (w_tmo) begin
                        r_err <= 1'b1;
                        if (!r_mem_we) r_bus_out <= 8'hFF;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ack       = w_ack;
    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.bus_out   = r_bus_out;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_bus_slave.sv
// Directed bench for bus_slave: latency, address assembly, read/write, timeout, reset.
module tb_bus_slave;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   acks = 0;
    int   a0;
    logic ack_q = 1'b0;

    bus_slave_if bif();
    bus_slave #(.TIMEOUT(8'd8)) dut (.clk(clk), .reset(reset), .bus(bif));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ack_q <= bif.ack;
        if (bif.ack && !ack_q) acks <= acks + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int which);
        return (which == 0) ? bif.ack : bif.mem_req;
    endfunction

    task automatic wait_sig(input string tag, input int which, input logic val);
        int n = 0;
        while (sig(which) !== val && n < 60) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, sig(which)}, {31'd0, val});
    endtask

    // rdy goes high right away, so consecutive calls leave a 1-cycle rdy low gap
    task automatic addr_phase(input logic [1:0] ctrl, input logic [7:0] d);
        bif.bus_ctrl = ctrl;
        bif.bus_in   = d;
        bif.rdy      = 1'b1;
        wait_sig("addr_ack_lo", 0, 1'b0);
        wait_sig("addr_ack_hi", 0, 1'b1);
        bif.rdy = 1'b0;
        tick();
    endtask

    task automatic data_start(input logic we, input logic [7:0] d);
        bif.bus_ctrl = 2'd3;
        bif.bus_in   = d;
        bif.bus_we   = we;
        bif.rdy      = 1'b1;
        wait_sig("data_ack_lo", 0, 1'b0);
        wait_sig("mem_req_up", 1, 1'b1);
    endtask

    task automatic mem_pulse(input logic [7:0] rd);
        bif.mem_ack   = 1'b1;
        bif.mem_rdata = rd;
        tick();
        bif.mem_ack   = 1'b0;
    endtask

    task automatic data_end();
        bif.rdy = 1'b0;
        wait_sig("data_ack_fall", 0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        bif.rdy = 1'b0; bif.bus_ctrl = 2'd0; bif.bus_in = 8'd0; bif.bus_we = 1'b0;
        bif.mem_rdata = 8'd0; bif.mem_ack = 1'b0;
        repeat (3) tick();
        chk("rst_ack", {31'd0, bif.ack}, 0);
        chk("rst_mem_req", {31'd0, bif.mem_req}, 0);
        chk("rst_mem_we", {31'd0, bif.mem_we}, 0);
        chk("rst_mem_addr", {8'd0, bif.mem_addr}, 0);
        chk("rst_mem_wdata", {24'd0, bif.mem_wdata}, 0);
        chk("rst_bus_out", {24'd0, bif.bus_out}, 0);
        chk("rst_err", {31'd0, bif.err}, 0);
        reset = 1'b0;
        tick();

        // address latency: ack on 3rd edge, falls 1 edge after rdy_s low
        bif.bus_ctrl = 2'd0; bif.bus_in = 8'h77; bif.rdy = 1'b1;
        tick(); tick();
        chk("lat_pre_ack", {31'd0, bif.ack}, 0);
        tick();
        chk("lat_ack_edge3", {31'd0, bif.ack}, 1);
        bif.bus_in = 8'h99;
        repeat (3) tick();
        chk("lat_ack_hold", {31'd0, bif.ack}, 1);
        bif.rdy = 1'b0;
        tick(); tick();
        chk("lat_ack_pre_fall", {31'd0, bif.ack}, 1);
        tick();
        chk("lat_ack_fall", {31'd0, bif.ack}, 0);
        repeat (5) tick();
        chk("lat_no_second_ack", {31'd0, bif.ack}, 0);

        // write with mem_ack 4 cycles after mem_req
        a0 = acks;
        addr_phase(2'd0, 8'h34);
        addr_phase(2'd1, 8'h12);
        addr_phase(2'd2, 8'h05);
        data_start(1'b1, 8'hA5);
        chk("wr_mem_addr", {8'd0, bif.mem_addr}, 32'h051234);
        chk("wr_mem_we", {31'd0, bif.mem_we}, 1);
        chk("wr_mem_wdata", {24'd0, bif.mem_wdata}, 32'hA5);
        tick(); tick(); tick();
        chk("wr_req_held", {31'd0, bif.mem_req}, 1);
        chk("wr_no_early_ack", {31'd0, bif.ack}, 0);
        mem_pulse(8'h00);
        chk("wr_ack", {31'd0, bif.ack}, 1);
        chk("wr_req_drop", {31'd0, bif.mem_req}, 0);
        chk("wr_err", {31'd0, bif.err}, 0);
        data_end();
        tick();
        chk("wr_ack_count", acks - a0, 4);

        // read returning 0x3C
        addr_phase(2'd0, 8'h34);
        addr_phase(2'd1, 8'h12);
        addr_phase(2'd2, 8'h05);
        data_start(1'b0, 8'h00);
        chk("rd_mem_we", {31'd0, bif.mem_we}, 0);
        chk("rd_mem_addr", {8'd0, bif.mem_addr}, 32'h051234);
        tick();
        chk("rd_bus_out_hold", {24'd0, bif.bus_out}, 0);
        mem_pulse(8'h3C);
        chk("rd_bus_out", {24'd0, bif.bus_out}, 32'h3C);
        chk("rd_ack", {31'd0, bif.ack}, 1);
        data_end();

        // read without address phases reuses the address
        data_start(1'b0, 8'h00);
        chk("reuse_mem_addr", {8'd0, bif.mem_addr}, 32'h051234);
        mem_pulse(8'h5A);
        chk("reuse_bus_out", {24'd0, bif.bus_out}, 32'h5A);
        data_end();

        // stray mem_ack while idle
        tick();
        mem_pulse(8'h77);
        tick();
        chk("stray_ack_bus_out", {24'd0, bif.bus_out}, 32'h5A);
        chk("stray_ack_no_ack", {31'd0, bif.ack}, 0);

        // mem_ack on the expiry edge is a success
        data_start(1'b0, 8'h00);
        repeat (7) tick();
        mem_pulse(8'h11);
        chk("edge_bus_out", {24'd0, bif.bus_out}, 32'h11);
        chk("edge_err", {31'd0, bif.err}, 0);
        chk("edge_ack", {31'd0, bif.ack}, 1);
        data_end();

        // write timeout: err set, bus_out kept
        data_start(1'b1, 8'hC3);
        repeat (8) tick();
        chk("wto_req_drop", {31'd0, bif.mem_req}, 0);
        chk("wto_err", {31'd0, bif.err}, 1);
        chk("wto_bus_out", {24'd0, bif.bus_out}, 32'h11);
        data_end();

        // read timeout: mem_req held 8 cycles, bus_out forced to FF
        data_start(1'b0, 8'h00);
        repeat (7) tick();
        chk("rto_req_held", {31'd0, bif.mem_req}, 1);
        tick();
        chk("rto_req_drop", {31'd0, bif.mem_req}, 0);
        chk("rto_ack", {31'd0, bif.ack}, 1);
        chk("rto_bus_out", {24'd0, bif.bus_out}, 32'hFF);
        chk("rto_err", {31'd0, bif.err}, 1);
        data_end();

        // reset in MEM_WAIT, then a late mem_ack
        data_start(1'b0, 8'h00);
        tick(); tick();
        reset = 1'b1; bif.rdy = 1'b0;
        tick();
        chk("mrst_req", {31'd0, bif.mem_req}, 0);
        chk("mrst_ack", {31'd0, bif.ack}, 0);
        reset = 1'b0;
        tick();
        mem_pulse(8'h42);
        repeat (4) tick();
        chk("mrst_late_req", {31'd0, bif.mem_req}, 0);
        chk("mrst_late_ack", {31'd0, bif.ack}, 0);
        chk("mrst_bus_out", {24'd0, bif.bus_out}, 0);
        chk("mrst_err", {31'd0, bif.err}, 0);

        // rdy held high through reset release gives exactly one phase
        reset = 1'b1;
        bif.bus_ctrl = 2'd0; bif.bus_in = 8'h66; bif.rdy = 1'b1;
        tick(); tick();
        a0 = acks;
        reset = 1'b0;
        wait_sig("rlse_ack", 0, 1'b1);
        repeat (6) tick();
        chk("rlse_ack_hold", {31'd0, bif.ack}, 1);
        bif.rdy = 1'b0;
        wait_sig("rlse_ack_fall", 0, 1'b0);
        repeat (4) tick();
        chk("rlse_one_ack", acks - a0, 1);
        data_start(1'b0, 8'h00);
        chk("rlse_mem_addr", {8'd0, bif.mem_addr}, 32'h000066);
        mem_pulse(8'h24);
        data_end();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
